// File: rtl/ila_uart_readout.sv
// ila_uart_readout: streams a captured ILA sample buffer out over the UART TX handshake.
// Optional trailing XOR checksum byte: define ILA_READOUT_CHECKSUM_EN.
module ila_uart_readout #(
    parameter int SAMPLE_WIDTH = 32,
    parameter int DEPTH        = 1024,
    localparam int ADDR_BITS    = $clog2(DEPTH),
    localparam int SAMPLE_BYTES = (SAMPLE_WIDTH + 7) / 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [ADDR_BITS-1:0]    i_start_ptr,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_rd_en,
    output logic [ADDR_BITS-1:0]    o_rd_addr,
    input  logic [SAMPLE_WIDTH-1:0] i_rd_data,
    output logic                    o_uart_tx_en,
    output logic [7:0]              o_uart_tx_data,
    input  logic                    i_uart_tx_done
);

    localparam int SH_W = SAMPLE_BYTES * 8;
    localparam int BI_W = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
    localparam logic [15:0] LEN = 16'(DEPTH);
    localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(SAMPLE_BYTES - 1);
    localparam logic [ADDR_BITS:0] LAST_SMP = (ADDR_BITS + 1)'(DEPTH - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_HSEND,
        S_HWAIT,
        S_RD,
        S_LAT,
        S_LOAD,
        S_SEND,
        S_WAIT,
`ifdef ILA_READOUT_CHECKSUM_EN
        S_CK,
        S_CKW,
`endif
        S_FIN
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_BITS-1:0]  r_ptr;
    logic [ADDR_BITS:0]    r_cnt;
    logic [1:0]            r_hidx;
    logic [BI_W-1:0]       r_bidx;
    logic [SH_W-1:0]       r_shreg;
    logic                  r_done;
    logic [7:0]            w_hdr_byte;
    logic [7:0]            w_top_byte;
    logic                  w_last_byte;
    logic                  w_last_smp;
`ifdef ILA_READOUT_CHECKSUM_EN
    logic [7:0]            r_ck;
`endif

    assign w_top_byte  = r_shreg[SH_W-1 -: 8];
    assign w_last_byte = (r_bidx == LAST_BYTE);
    assign w_last_smp  = (r_cnt == LAST_SMP);

    // Header byte selected by the header index: sync, then length MSB, LSB
    always_comb begin
        w_hdr_byte = 8'hA5;
        unique case (r_hidx)
            2'd1:    w_hdr_byte = LEN[15:8];
            2'd2:    w_hdr_byte = LEN[7:0];
            default: w_hdr_byte = 8'hA5;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (i_start) w_next = S_HDR;
            S_HDR:   w_next = S_HSEND;
            S_HSEND: w_next = S_HWAIT;
            S_HWAIT: begin
                if (i_uart_tx_done) begin
                    w_next = (r_hidx == 2'd2) ? S_RD : S_HSEND;
                end
            end
            S_RD:    w_next = S_LAT;
            S_LAT:   w_next = S_LOAD;
            S_LOAD:  w_next = S_SEND;
            S_SEND:  w_next = S_WAIT;
            S_WAIT: begin
                if (i_uart_tx_done) begin
                    if (!w_last_byte) begin
                        w_next = S_SEND;
                    end else if (!w_last_smp) begin
                        w_next = S_RD;
                    end else begin
`ifdef ILA_READOUT_CHECKSUM_EN
                        w_next = S_CK;
`else
                        w_next = S_FIN;
`endif
                    end
                end
            end
`ifdef ILA_READOUT_CHECKSUM_EN
            S_CK:    w_next = S_CKW;
            S_CKW:   if (i_uart_tx_done) w_next = S_FIN;
`endif
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state and datapath registers
    always_comb begin
        o_busy         = (r_state != S_IDLE);
        o_done         = r_done;
        o_rd_en        = (r_state == S_RD);
        o_rd_addr      = r_ptr;
        o_uart_tx_en   = 1'b0;
        o_uart_tx_data = 8'h00;
        unique case (r_state)
            S_HSEND: begin
                o_uart_tx_en   = 1'b1;
                o_uart_tx_data = w_hdr_byte;
            end
            S_HWAIT: o_uart_tx_data = w_hdr_byte;
            S_SEND: begin
                o_uart_tx_en   = 1'b1;
                o_uart_tx_data = w_top_byte;
            end
            S_WAIT:  o_uart_tx_data = w_top_byte;
`ifdef ILA_READOUT_CHECKSUM_EN
            S_CK: begin
                o_uart_tx_en   = 1'b1;
                o_uart_tx_data = r_ck;
            end
            S_CKW:   o_uart_tx_data = r_ck;
`endif
            default: begin
                o_uart_tx_en   = 1'b0;
                o_uart_tx_data = 8'h00;
            end
        endcase
    end

    // Pointer, counters, shift register and done pulse (done lags FIN by one)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_hidx  <= '0;
            r_bidx  <= '0;
            r_shreg <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIN);
            if (r_state == S_IDLE && i_start) begin
                r_ptr  <= i_start_ptr;
                r_cnt  <= '0;
                r_hidx <= '0;
                r_bidx <= '0;
            end
            if (r_state == S_HWAIT && i_uart_tx_done) begin
                r_hidx <= r_hidx + 2'd1;
            end
            if (r_state == S_LOAD) begin
                r_shreg <= SH_W'(i_rd_data);
                r_bidx  <= '0;
            end
            if (r_state == S_WAIT && i_uart_tx_done) begin
                r_shreg <= r_shreg << 8;
                r_bidx  <= r_bidx + 1'b1;
                if (w_last_byte) begin
                    r_ptr <= r_ptr + 1'b1;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

`ifdef ILA_READOUT_CHECKSUM_EN
    // XOR of every byte after the sync byte
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ck <= 8'h00;
        end else if (r_state == S_IDLE && i_start) begin
            r_ck <= 8'h00;
        end else if (r_state == S_HWAIT && i_uart_tx_done && r_hidx != 2'd0) begin
            r_ck <= r_ck ^ w_hdr_byte;
        end else if (r_state == S_WAIT && i_uart_tx_done) begin
            r_ck <= r_ck ^ w_top_byte;
        end
    end
`endif

endmodule

// File: tb/tb_ila_uart_readout.sv
// tb_ila_uart_readout: directed frames against a buffer model and a UART model.
// Two instances: 12-bit x 4 (slow UART) and 16-bit x 2 (1-cycle UART).
module tb_ila_uart_readout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    logic rst = 1'b1;

    // Instance A: SAMPLE_WIDTH=12, DEPTH=4
    logic        a_start = 1'b0;
    logic [1:0]  a_start_ptr = 2'd0;
    logic        a_busy, a_done, a_rd_en, a_tx_en, a_tx_done;
    logic [1:0]  a_rd_addr;
    logic [11:0] a_rd_data = '0;
    logic [7:0]  a_tx_data;
    logic        a_mdone = 1'b0;
    logic        a_inj = 1'b0;
    int          a_pend = 0;
    int          a_dones = 0;
    logic [7:0]  a_bytes[$];
    int          a_rdq[$];
    logic [11:0] a_mem [4];

    assign a_tx_done = a_mdone | a_inj;

    ila_uart_readout #(.SAMPLE_WIDTH(12), .DEPTH(4)) u_a (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (a_start),
        .i_start_ptr    (a_start_ptr),
        .o_busy         (a_busy),
        .o_done         (a_done),
        .o_rd_en        (a_rd_en),
        .o_rd_addr      (a_rd_addr),
        .i_rd_data      (a_rd_data),
        .o_uart_tx_en   (a_tx_en),
        .o_uart_tx_data (a_tx_data),
        .i_uart_tx_done (a_tx_done)
    );

    always @(posedge clk) if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];

    always @(negedge clk) begin
        a_mdone = 1'b0;
        if (a_pend != 0) begin
            a_pend--;
            if (a_pend == 0) a_mdone = 1'b1;
        end
        if (a_tx_en) begin
            a_bytes.push_back(a_tx_data);
            a_pend = 10;
        end
        if (a_rd_en) a_rdq.push_back(int'(a_rd_addr));
        if (a_done) a_dones++;
    end

    // Instance B: SAMPLE_WIDTH=16, DEPTH=2
    logic        b_start = 1'b0;
    logic        b_start_ptr = 1'b0;
    logic        b_busy, b_done, b_rd_en, b_tx_en, b_tx_done;
    logic        b_rd_addr;
    logic [15:0] b_rd_data = '0;
    logic [7:0]  b_tx_data;
    logic        b_mdone = 1'b0;
    int          b_pend = 0;
    int          b_dones = 0;
    int          b_done_cyc = 0;
    logic        b_busy_at_done = 1'b1;
    logic [7:0]  b_bytes[$];
    int          b_ec[$];
    int          b_dc[$];
    logic [15:0] b_mem [2];

    assign b_tx_done = b_mdone;

    ila_uart_readout #(.SAMPLE_WIDTH(16), .DEPTH(2)) u_b (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (b_start),
        .i_start_ptr    (b_start_ptr),
        .o_busy         (b_busy),
        .o_done         (b_done),
        .o_rd_en        (b_rd_en),
        .o_rd_addr      (b_rd_addr),
        .i_rd_data      (b_rd_data),
        .o_uart_tx_en   (b_tx_en),
        .o_uart_tx_data (b_tx_data),
        .i_uart_tx_done (b_tx_done)
    );

    always @(posedge clk) if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];

    always @(negedge clk) begin
        b_mdone = 1'b0;
        if (b_pend != 0) begin
            b_pend--;
            if (b_pend == 0) begin
                b_mdone = 1'b1;
                b_dc.push_back(cyc);
            end
        end
        if (b_tx_en) begin
            b_bytes.push_back(b_tx_data);
            b_ec.push_back(cyc);
            b_pend = 1;
        end
        if (b_done) begin
            b_dones++;
            b_done_cyc = cyc;
            b_busy_at_done = b_busy;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_frame(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        chk({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i), (i < got.size()) ? {24'd0, got[i]} : 32'hDEAD, {24'd0, exp[i]});
        end
    endtask

    task automatic pulse_a(input logic [1:0] ptr);
        @(negedge clk);
        a_start_ptr = ptr;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic wait_a_done(input string tag, input int base);
        int n;
        n = 0;
        while (a_dones == base && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, a_dones > base, 1);
        repeat (5) @(negedge clk);
        chk({tag, "_one_done"}, a_dones, base + 1);
    endtask

    task automatic clr_a();
        a_bytes.delete();
        a_rdq.delete();
    endtask

    logic [7:0] exp1[$];
    logic [7:0] exp2[$];
    logic [7:0] expb[$];

    initial begin
        int base;
        int n;
        a_mem[0] = 12'h123;
        a_mem[1] = 12'h456;
        a_mem[2] = 12'h789;
        a_mem[3] = 12'hABC;
        b_mem[0] = 16'hFFFF;
        b_mem[1] = 16'h0001;
        exp1 = '{8'hA5, 8'h00, 8'h04, 8'h01, 8'h23, 8'h04, 8'h56, 8'h07, 8'h89, 8'h0A, 8'hBC};
        exp2 = '{8'hA5, 8'h00, 8'h04, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h04, 8'h56, 8'h07, 8'h89};
        expb = '{8'hA5, 8'h00, 8'h02, 8'hFF, 8'hFF, 8'h00, 8'h01};
`ifdef ILA_READOUT_CHECKSUM_EN
        exp1.push_back(8'h4C);
        exp2.push_back(8'h4C);
        expb.push_back(8'h03);
`endif

        repeat (3) @(negedge clk);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_rd_en", a_rd_en, 0);
        chk("rst_rd_addr", a_rd_addr, 0);
        chk("rst_tx_en", a_tx_en, 0);
        chk("rst_tx_data", a_tx_data, 0);
        chk("rst_b_busy", b_busy, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Frame from pointer 0
        clr_a();
        base = a_dones;
        pulse_a(2'd0);
        wait_a_done("p0", base);
        cmp_frame("p0", a_bytes, exp1);
        chk("p0_nrd", a_rdq.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("p0_rd%0d", i), (i < a_rdq.size()) ? a_rdq[i] : 99, i);
        chk("p0_idle_busy", a_busy, 0);

        // Frame from pointer 3 (wraps)
        clr_a();
        base = a_dones;
        pulse_a(2'd3);
        wait_a_done("p3", base);
        cmp_frame("p3", a_bytes, exp2);
        chk("p3_nrd", a_rdq.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("p3_rd%0d", i), (i < a_rdq.size()) ? a_rdq[i] : 99, (i + 3) % 4);

        // Stray start and stray tx_done mid-frame
        clr_a();
        base = a_dones;
        pulse_a(2'd0);
        n = 0;
        while (!a_rd_en && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("dist_rd_seen", a_rd_en, 1);
        a_inj = 1'b1;
        a_start = 1'b1;
        a_start_ptr = 2'd2;
        @(negedge clk);
        a_inj = 1'b0;
        a_start = 1'b0;
        repeat (15) @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_a_done("dist", base);
        cmp_frame("dist", a_bytes, exp1);
        chk("dist_nrd", a_rdq.size(), 4);

        // Reset while a sample byte is outstanding
        clr_a();
        pulse_a(2'd0);
        n = 0;
        while (a_bytes.size() < 4 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("mr_in_wait", a_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_busy", a_busy, 0);
        chk("mr_done", a_done, 0);
        chk("mr_rd_en", a_rd_en, 0);
        chk("mr_rd_addr", a_rd_addr, 0);
        chk("mr_tx_en", a_tx_en, 0);
        chk("mr_tx_data", a_tx_data, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("mr_stay_idle", a_busy, 0);
        clr_a();
        base = a_dones;
        pulse_a(2'd0);
        wait_a_done("mr", base);
        cmp_frame("mr", a_bytes, exp1);

        // Tight UART timing on instance B
        @(negedge clk);
        b_start_ptr = 1'b0;
        b_start = 1'b1;
        base = cyc;
        @(negedge clk);
        b_start = 1'b0;
        n = 0;
        while (b_dones == 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("b_done_seen", b_dones, 1);
        repeat (5) @(negedge clk);
        chk("b_one_done", b_dones, 1);
        cmp_frame("b", b_bytes, expb);
        if (b_ec.size() >= 6 && b_dc.size() >= 6) begin
            chk("b_start_to_en", b_ec[0] - base, 2);
            chk("b_hdr_gap", b_ec[1] - b_dc[0], 1);
            chk("b_byte_gap", b_ec[4] - b_dc[3], 1);
            chk("b_smp_gap", b_ec[5] - b_dc[4], 4);
            chk("b_done_lat", b_done_cyc - b_dc[b_dc.size() - 1], 2);
        end else begin
            chk("b_q_size", 0, 1);
        end
        chk("b_busy_at_done", b_busy_at_done, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
